// File: rtl/m2visdq.sv
// MPEG-2 inverse zigzag scan and inverse quantisation: run/level pairs in, dequantised,
// saturated, mismatch-controlled raster-order coefficients out to the IDCT buffer.
//
// state       | meaning
// ST_IDLE     | waiting for block_start
// ST_BLOCK    | accepting run/level pairs
// ST_DRAIN    | block_end seen, flushing pipeline
// ST_MISMATCH | emitting the addr-63 mismatch beat
module m2visdq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        softreset,
   input  logic        pict_valid,
   input  logic        pict_qstype,
   input  logic [1:0]  pict_dcprec,
   input  logic        block_start,
   input  logic        block_end,
   input  logic        blk_intra,
   input  logic [4:0]  blk_qscode,
   input  logic        rl_valid,
   input  logic [5:0]  run,
   input  logic        level_sign,
   input  logic [10:0] level_data,
   output logic        ready_isdq,
   input  logic        qm_valid,
   input  logic        qm_custom,
   input  logic        qm_intra,
   input  logic [7:0]  qm_value,
   output logic        coef_valid,
   output logic [5:0]  coef_addr,
   output logic [11:0] coef_data,
   output logic        coef_last,
   input  logic        ready_idct,
   output logic        err_overrun
);

   typedef enum logic [1:0] {ST_IDLE, ST_BLOCK, ST_DRAIN, ST_MISMATCH} state_t;

   localparam logic [5:0] ZIGZAG [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

   // Default intra matrix, raster order.
   localparam logic [7:0] INTRA_DEF [64] = '{
      8'd8,  8'd16, 8'd19, 8'd22, 8'd26, 8'd27, 8'd29, 8'd34,
      8'd16, 8'd16, 8'd22, 8'd24, 8'd27, 8'd29, 8'd34, 8'd37,
      8'd19, 8'd22, 8'd26, 8'd27, 8'd29, 8'd34, 8'd34, 8'd38,
      8'd22, 8'd22, 8'd26, 8'd27, 8'd29, 8'd34, 8'd37, 8'd40,
      8'd22, 8'd26, 8'd27, 8'd29, 8'd32, 8'd35, 8'd40, 8'd48,
      8'd26, 8'd27, 8'd29, 8'd32, 8'd35, 8'd40, 8'd48, 8'd58,
      8'd26, 8'd27, 8'd29, 8'd34, 8'd38, 8'd46, 8'd56, 8'd69,
      8'd27, 8'd29, 8'd35, 8'd38, 8'd46, 8'd56, 8'd69, 8'd83};

   localparam logic [6:0] QS_NL [32] = '{
      7'd0,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  7'd7,
      7'd8,  7'd10, 7'd12, 7'd14, 7'd16, 7'd18, 7'd20, 7'd22,
      7'd24, 7'd28, 7'd32, 7'd36, 7'd40, 7'd44, 7'd48, 7'd52,
      7'd56, 7'd64, 7'd72, 7'd80, 7'd88, 7'd96, 7'd104, 7'd112};

   state_t state, state_nxt;
   logic   rst, adv, accept, pair_drop;

   logic       qstype_q;
   logic [1:0] dcprec_q;
   logic       blk_intra_q;
   logic [4:0] qscode_q;
   logic       first_q, dropped_q;
   logic [5:0] prev_pos;
   logic [6:0] pos_calc;

   logic [7:0] mat_intra    [64];
   logic [7:0] mat_nonintra [64];
   logic       use_custom_intra, use_custom_nonintra;
   logic [5:0] cnt_intra, cnt_nonintra;

   logic        s1_valid, s1_sign, s1_dc;
   logic [5:0]  s1_addr;
   logic [10:0] s1_qf;
   logic [7:0]  w_sel;
   logic [6:0]  qscale;
   logic [27:0] prod_calc;

   logic        s2_valid, s2_sign, s2_dc;
   logic [5:0]  s2_addr;
   logic [27:0] s2_prod;
   logic [27:0] mag;
   logic [11:0] sat_data;

   logic               parity_q;
   logic [11:0]        v63_q;
   logic signed [12:0] mm_wide;
   logic [11:0]        mm_data;

   assign rst = ~reset_n | softreset;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      adv        = ~coef_valid | ready_idct;
      ready_isdq = 1'b0;
      case (state)
         ST_IDLE: begin
            if (block_start) state_nxt = block_end ? ST_DRAIN : ST_BLOCK;
         end
         ST_BLOCK: begin
            ready_isdq = adv;
            if (block_end) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!s1_valid && !s2_valid && !coef_valid) state_nxt = ST_MISMATCH;
         end
         ST_MISMATCH: begin
            if (coef_valid && coef_last && ready_idct) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign accept = rl_valid & ready_isdq;

   always_comb begin
      pos_calc  = first_q ? {1'b0, run} : {1'b0, prev_pos} + {1'b0, run} + 7'd1;
      pair_drop = dropped_q | pos_calc[6];
   end

   // Picture and block context, scan position tracking, overrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         qstype_q    <= 1'b0;
         dcprec_q    <= 2'd0;
         blk_intra_q <= 1'b0;
         qscode_q    <= 5'd0;
         first_q     <= 1'b1;
         dropped_q   <= 1'b0;
         prev_pos    <= 6'd0;
         err_overrun <= 1'b0;
      end else begin
         if (pict_valid) begin
            qstype_q <= pict_qstype;
            dcprec_q <= pict_dcprec;
         end
         if (state == ST_IDLE && block_start) begin
            blk_intra_q <= blk_intra;
            qscode_q    <= blk_qscode;
            first_q     <= 1'b1;
            dropped_q   <= 1'b0;
            prev_pos    <= 6'd0;
         end else if (accept) begin
            if (pair_drop) begin
               dropped_q   <= 1'b1;
               err_overrun <= 1'b1;
            end else begin
               first_q  <= 1'b0;
               prev_pos <= pos_calc[5:0];
            end
         end
      end
   end

   // Quant matrix loads are accepted in any state; each matrix keeps its own write pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         use_custom_intra    <= 1'b0;
         use_custom_nonintra <= 1'b0;
         cnt_intra           <= 6'd0;
         cnt_nonintra        <= 6'd0;
      end else if (qm_valid) begin
         if (qm_intra) begin
            use_custom_intra <= qm_custom;
            cnt_intra        <= qm_custom ? cnt_intra + 6'd1 : 6'd0;
         end else begin
            use_custom_nonintra <= qm_custom;
            cnt_nonintra        <= qm_custom ? cnt_nonintra + 6'd1 : 6'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && qm_valid && qm_custom) begin
         if (qm_intra) mat_intra[ZIGZAG[cnt_intra]] <= qm_value;
         else          mat_nonintra[ZIGZAG[cnt_nonintra]] <= qm_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_addr  <= 6'd0;
         s1_sign  <= 1'b0;
         s1_qf    <= 11'd0;
         s1_dc    <= 1'b0;
      end else if (adv) begin
         s1_valid <= accept & ~pair_drop;
         s1_addr  <= ZIGZAG[pos_calc[5:0]];
         s1_sign  <= level_sign;
         s1_qf    <= level_data;
         s1_dc    <= blk_intra_q & (pos_calc == 7'd0);
      end
   end

   always_comb begin
      w_sel = 8'd16;
      if (blk_intra_q) w_sel = use_custom_intra ? mat_intra[s1_addr] : INTRA_DEF[s1_addr];
      else if (use_custom_nonintra) w_sel = mat_nonintra[s1_addr];
      qscale = qstype_q ? QS_NL[qscode_q] : {1'b0, qscode_q, 1'b0};
   end

   // 2*QF+k is formed by appending k as the LSB.
   always_comb begin
      if (s1_dc) prod_calc = {17'd0, s1_qf} << (2'd3 - dcprec_q);
      else       prod_calc = 28'({s1_qf, ~blk_intra_q}) * 28'(w_sel) * 28'(qscale);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_addr  <= 6'd0;
         s2_sign  <= 1'b0;
         s2_dc    <= 1'b0;
         s2_prod  <= 28'd0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
         s2_sign  <= s1_sign;
         s2_dc    <= s1_dc;
         s2_prod  <= prod_calc;
      end
   end

   always_comb begin
      mag = s2_dc ? s2_prod : {5'd0, s2_prod[27:5]};
      if (s2_sign) sat_data = (mag > 28'd2048) ? 12'h800 : (~mag[11:0] + 12'd1);
      else         sat_data = (mag > 28'd2047) ? 12'h7FF : mag[11:0];
   end

   always_comb begin
      mm_wide = {v63_q[11], v63_q};
      if (!parity_q) mm_wide = v63_q[0] ? mm_wide - 13'sd1 : mm_wide + 13'sd1;
      if (mm_wide > 13'sd2047)       mm_data = 12'h7FF;
      else if (mm_wide < -13'sd2048) mm_data = 12'h800;
      else                           mm_data = mm_wide[11:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coef_valid <= 1'b0;
         coef_addr  <= 6'd0;
         coef_data  <= 12'd0;
         coef_last  <= 1'b0;
      end else if (adv) begin
         if (state == ST_MISMATCH && !coef_valid) begin
            coef_valid <= 1'b1;
            coef_addr  <= 6'd63;
            coef_data  <= mm_data;
            coef_last  <= 1'b1;
         end else begin
            coef_valid <= s2_valid;
            coef_last  <= 1'b0;
            if (s2_valid) begin
               coef_addr <= s2_addr;
               coef_data <= sat_data;
            end
         end
      end
   end

   // Mismatch bookkeeping follows beats actually taken by the IDCT.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
         v63_q    <= 12'd0;
      end else if (state == ST_IDLE && block_start) begin
         parity_q <= 1'b0;
         v63_q    <= 12'd0;
      end else if (coef_valid && ready_idct && !coef_last) begin
         parity_q <= parity_q ^ coef_data[0];
         if (coef_addr == 6'd63) v63_q <= coef_data;
      end
   end

endmodule
